// File: rtl/data_ram_resp_if.sv
// Word-wide load/store port between the MEM stage (master) and the data RAM
// responder (slave). Signal names keep the responder's point of view.
//   ce_i    request valid (chip enable)
//   we_i    1 = write, 0 = read
//   addr_i  byte address
//   data_i  write data
//   data_o  read data / written word, valid with ready_o
//   ready_o one-cycle completion pulse
//   busy_o  request in flight
//   err_o   out-of-range flag, valid with ready_o
interface data_ram_resp_if;
  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ready_o;
  logic        busy_o;
  logic        err_o;

  modport master (
    output ce_i, we_i, addr_i, data_i,
    input  data_o, ready_o, busy_o, err_o
  );

  modport slave (
    input  ce_i, we_i, addr_i, data_i,
    output data_o, ready_o, busy_o, err_o
  );
endinterface

// File: rtl/data_ram_resp.sv
// Data-memory responder: RAM end of the MEM-stage word load/store port.
// Accepts one whole-word read or write per request and completes LATENCY
// cycles after the accept with a one-cycle ready_o pulse.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    data_ram_resp_if.slave (ce/we/addr/data in; data/ready/busy/err out)
// Parameters:
//   DEPTH_LOG2  log2 of the number of 32-bit words
//   LATENCY     accept-to-ready distance in cycles, 1..15
module data_ram_resp #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input logic             clk_i,
  input logic             rst_i,
  data_ram_resp_if.slave  bus
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // Latched request
  logic        we_q;
  logic [29:0] waddr_q;
  logic [31:0] wdata_q;

  logic                  accept;
  logic                  oor;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  mem_we;
  logic [31:0]           ram_rdata_q;
  logic [31:0]           done_data;
  logic [31:0]           hold_q;
  logic                  unused_addr_lsb;

  logic [31:0] mem [Depth];

  assign unused_addr_lsb = ^bus.addr_i[1:0];

  assign accept = (state_q == StIdle) && bus.ce_i;
  assign idx_q  = waddr_q[DEPTH_LOG2-1:0];
  assign oor    = (waddr_q[29:DEPTH_LOG2] != '0);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.ce_i) begin
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? StDone : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request capture; inputs are ignored outside the accept edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= bus.we_i;
      waddr_q <= bus.addr_i[31:2];
      wdata_q <= bus.data_i;
    end
  end

  // With LATENCY=1 the edge entering DONE is the accept edge itself, so the
  // read address has to come straight from the bus while idle.
  assign rd_idx = (state_q == StIdle) ? bus.addr_i[DEPTH_LOG2+1:2] : idx_q;

  // Reset on the commit edge drops the write.
  assign mem_we = (state_q == StDone) && we_q && !oor && !rst_i;

  // Single-port array with a registered read, no reset so it maps to block RAM.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
    ram_rdata_q <= mem[rd_idx];
  end

  // Value presented during DONE: zero on error, write-through on writes.
  always_comb begin
    done_data = ram_rdata_q;
    if (oor) begin
      done_data = '0;
    end else if (we_q) begin
      done_data = wdata_q;
    end
  end

  // Keeps data_o stable between completions.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q <= '0;
    end else if (state_q == StDone) begin
      hold_q <= done_data;
    end
  end

  // Outputs
  always_comb begin
    bus.ready_o = (state_q == StDone);
    bus.busy_o  = (state_q != StIdle);
    bus.err_o   = (state_q == StDone) && oor;
    bus.data_o  = (state_q == StDone) ? done_data : hold_q;
  end

endmodule

// File: tb/tb_data_ram_resp.sv
module tb_data_ram_resp;

  localparam int unsigned L2 = 2;
  localparam int unsigned L1 = 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  exp_t q2[$];
  exp_t q1[$];
  exp_t e2;
  exp_t e1;

  data_ram_resp_if bus2 ();
  data_ram_resp_if bus1 ();

  data_ram_resp #(.DEPTH_LOG2(10), .LATENCY(L2)) dut2 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus2.slave)
  );

  data_ram_resp #(.DEPTH_LOG2(10), .LATENCY(L1)) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus1.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // A response is due in the interval following edge (accept edge + LATENCY - 1),
  // i.e. LATENCY cycles after the accept.
  always @(negedge clk) begin
    if (mon_en && bus2.ready_o) begin
      if (q2.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL l2_spurious_ready: got ready_o=1 at cycle %0d expected none", cyc);
      end else begin
        e2 = q2.pop_front();
        check("l2_data", bus2.data_o, e2.data);
        check("l2_err", {31'b0, bus2.err_o}, {31'b0, e2.err});
        check("l2_ready_cycle", 32'(cyc), 32'(e2.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && bus1.ready_o) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL l1_spurious_ready: got ready_o=1 at cycle %0d expected none", cyc);
      end else begin
        e1 = q1.pop_front();
        check("l1_data", bus1.data_o, e1.data);
        check("l1_err", {31'b0, bus1.err_o}, {31'b0, e1.err});
        check("l1_ready_cycle", 32'(cyc), 32'(e1.cyc));
      end
    end
  end

  task automatic drive(input int sel, input logic ce, input logic we,
                       input logic [31:0] addr, input logic [31:0] data);
    if (sel == 2) begin
      bus2.ce_i = ce; bus2.we_i = we; bus2.addr_i = addr; bus2.data_i = data;
    end else begin
      bus1.ce_i = ce; bus1.we_i = we; bus1.addr_i = addr; bus1.data_i = data;
    end
  endtask

  // Called #1 after the accept edge, so cyc already holds that edge's number.
  task automatic push(input int sel, input logic [31:0] d, input logic err);
    exp_t e;
    e.data = d;
    e.err  = err;
    if (sel == 2) begin
      e.cyc = cyc + int'(L2) - 1;
      q2.push_back(e);
    end else begin
      e.cyc = cyc + int'(L1) - 1;
      q1.push_back(e);
    end
  endtask

  // Issue one request from IDLE and return once the DUT is IDLE again.
  task automatic do_req(input int sel, input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_d, input logic exp_e);
    drive(sel, 1'b1, we, addr, data);
    @(posedge clk); #1;
    push(sel, exp_d, exp_e);
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat ((sel == 2) ? L2 : L1) @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] PreAddr [3] = '{32'h0, 32'h4, 32'h8};
  localparam logic [31:0] PreData [3] = '{32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hC2C2_C2C2};

  initial begin
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready2", {31'b0, bus2.ready_o}, 32'h0);
    check("rst_busy2", {31'b0, bus2.busy_o}, 32'h0);
    check("rst_err2", {31'b0, bus2.err_o}, 32'h0);
    check("rst_data2", bus2.data_o, 32'h0);
    check("rst_ready1", {31'b0, bus1.ready_o}, 32'h0);
    check("rst_busy1", {31'b0, bus1.busy_o}, 32'h0);
    check("rst_data1", bus1.data_o, 32'h0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Write then read back at LATENCY=2
    do_req(2, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    do_req(2, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Out-of-range write must not alias onto word 0
    do_req(2, 1'b1, 32'h0000_0000, 32'h1111_0000, 32'h1111_0000, 1'b0);
    do_req(2, 1'b1, 32'h0000_1000, 32'h55AA_55AA, 32'h0, 1'b1);
    do_req(2, 1'b0, 32'h0000_0000, 32'h0, 32'h1111_0000, 1'b0);
    do_req(2, 1'b0, 32'h8000_0004, 32'h0, 32'h0, 1'b1);

    // Reset during WAIT drops the pending write
    do_req(2, 1'b1, 32'h0000_0020, 32'hCAFE_0020, 32'hCAFE_0020, 1'b0);
    drive(2, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678);
    @(posedge clk); #1;
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'b0, bus2.busy_o}, 32'h0);
    check("midrst_ready", {31'b0, bus2.ready_o}, 32'h0);
    check("midrst_data", bus2.data_o, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    do_req(2, 1'b0, 32'h0000_0020, 32'h0, 32'hCAFE_0020, 1'b0);

    // Low address bits are ignored
    do_req(2, 1'b0, 32'h0000_0023, 32'h0, 32'hCAFE_0020, 1'b0);

    // ce held with a changing address through WAIT and DONE
    drive(2, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    @(posedge clk); #1;
    push(2, 32'hDEAD_BEEF, 1'b0);
    drive(2, 1'b1, 1'b1, 32'h0000_0020, 32'h7777_7777);
    @(negedge clk);
    check("hold_busy_wait", {31'b0, bus2.busy_o}, 32'h1);
    @(posedge clk); #1;
    drive(2, 1'b1, 1'b1, 32'h0000_0000, 32'h6666_6666);
    @(negedge clk);
    check("hold_busy_done", {31'b0, bus2.busy_o}, 32'h1);
    @(posedge clk); #1;
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("hold_busy_idle", {31'b0, bus2.busy_o}, 32'h0);
    check("hold_data_stable", bus2.data_o, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    do_req(2, 1'b0, 32'h0000_0020, 32'h0, 32'hCAFE_0020, 1'b0);
    do_req(2, 1'b0, 32'h0000_0000, 32'h0, 32'h1111_0000, 1'b0);

    // LATENCY=1: preload, then continuous reads, one every second cycle
    for (int i = 0; i < 3; i++) begin
      do_req(1, 1'b1, PreAddr[i], PreData[i], PreData[i], 1'b0);
    end
    drive(1, 1'b1, 1'b0, PreAddr[0], 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1'b1, 1'b0, PreAddr[i], 32'h0);
      @(posedge clk); #1;
      push(1, PreData[i], 1'b0);
      if (i < 2) drive(1, 1'b1, 1'b0, PreAddr[i+1], 32'h0);
      @(posedge clk); #1;
    end
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

    repeat (5) @(posedge clk);
    #1;
    check("q2_drained", 32'(q2.size()), 32'h0);
    check("q1_drained", 32'(q1.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
